// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, inst, excep} between fetch and decode.
// Optional macro IFQ_BYPASS_EN adds a zero-latency wr->rd path when the queue is empty.
module inst_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int EXC_W    = 32,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic [31:0]      wr_pc,
  input  logic [31:0]      wr_inst,
  input  logic [EXC_W-1:0] wr_excep,
  output logic             wr_ready,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [31:0]      rd_pc,
  output logic [31:0]      rd_inst,
  output logic [EXC_W-1:0] rd_excep,
  output logic             stall_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] AF = (AW+1)'(AF_LEVEL);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_inst [DEPTH];
  logic [EXC_W-1:0] r_exc  [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count;
  logic [AW-1:0]    w_widx;
  logic [AW-1:0]    w_ridx;

  always_comb begin
    w_widx  = r_wptr[AW-1:0];
    w_ridx  = r_rptr[AW-1:0];
    w_empty = (r_wptr == r_rptr);
    w_full  = (w_widx == w_ridx) &&
              (r_wptr[AW] != r_rptr[AW]);
    w_count = r_wptr - r_rptr;
`ifdef IFQ_BYPASS_EN
    w_byp   = w_empty & wr_valid & ~flush;
`else
    w_byp   = 1'b0;
`endif
  end

  // flush blocks both handshakes so nothing moves in the redirect cycle
  always_comb begin
    wr_ready = ~w_full & ~flush;
    rd_valid = ~flush & (~w_empty | w_byp);
    w_push   = wr_valid & wr_ready &
               ~(w_byp & rd_ready);
    w_pop    = rd_valid & rd_ready & ~w_empty;
    stall_o  = (w_count >= AF);
    count_o  = w_count;
  end

  always_comb begin
    rd_pc    = '0;
    rd_inst  = '0;
    rd_excep = '0;
    if (w_byp) begin
      rd_pc    = wr_pc;
      rd_inst  = wr_inst;
      rd_excep = wr_excep;
    end else if (rd_valid) begin
      rd_pc    = r_pc[w_ridx];
      rd_inst  = r_inst[w_ridx];
      rd_excep = r_exc[w_ridx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // entry storage is intentionally not reset; validity comes from the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[w_widx]   <= wr_pc;
      r_inst[w_widx] <= wr_inst;
      r_exc[w_widx]  <= wr_excep;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed scenarios plus random traffic.
// Expected entries come from a plain FIFO model held in a SystemVerilog queue.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AF    = 3;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_pc = '0;
  logic [31:0] wr_inst = '0;
  logic [31:0] wr_excep = '0;
  logic        wr_ready;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_inst;
  logic [31:0] rd_excep;
  logic        stall_o;
  logic [2:0]  count_o;

  int   total = 0;
  int   bad = 0;
  int   mcount = 0;
  ent_t exp_q[$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .AF_LEVEL(AF), .EXC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_pc(wr_pc),
    .wr_inst(wr_inst), .wr_excep(wr_excep),
    .wr_ready(wr_ready), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_inst(rd_inst), .rd_excep(rd_excep),
    .stall_o(stall_o), .count_o(count_o)
  );

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, req, $time);
    end
  endtask

  // monitor: samples just before the rising edge
  always begin
    bit   byp;
    ent_t e;
    @(negedge clk);
    #4;
    if (rst) begin
      byp = 1'b0;
`ifdef IFQ_BYPASS_EN
      byp = (mcount == 0) && wr_valid && !flush;
`endif
      chk("count", 64'(count_o), 64'(mcount));
      chk("rd_valid", 64'(rd_valid),
          64'((mcount > 0 || byp) && !flush));
      chk("wr_ready", 64'(wr_ready),
          64'(mcount < DEPTH && !flush));
      chk("stall", 64'(stall_o), 64'(mcount >= AF));
      if (rd_valid && rd_ready) begin
`ifdef IFQ_BYPASS_EN
        if (byp) begin
          chk("byp_pc", 64'(rd_pc), 64'(wr_pc));
          chk("byp_exc", 64'(rd_excep), 64'(wr_excep));
        end else
`endif
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL underflow actual=pop required=none t=%0t",
                   $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd_pc", 64'(rd_pc), 64'(e.pc));
          chk("rd_inst", 64'(rd_inst), 64'(e.inst));
          chk("rd_exc", 64'(rd_excep), 64'(e.exc));
        end
      end else if (!rd_valid) begin
        chk("mask_pc", 64'(rd_pc), 64'd0);
        chk("mask_exc", 64'(rd_excep), 64'd0);
      end
    end
  end

  // driver: one cycle of stimulus, then model update at the edge
  task automatic cyc(bit wv, logic [31:0] pc,
                     logic [31:0] exc, bit rr, bit fl);
    bit   b;
    bit   rf;
    bit   wf;
    ent_t e;
    @(negedge clk);
    wr_valid = wv;
    wr_pc    = pc;
    wr_inst  = pc ^ 32'h5a5a_1234;
    wr_excep = exc;
    rd_ready = rr;
    flush    = fl;
    @(posedge clk);
    if (!rst || fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      b = 1'b0;
`ifdef IFQ_BYPASS_EN
      b = (mcount == 0) && wv;
`endif
      rf = (mcount > 0) && rr;
      wf = wv && (mcount < DEPTH) && !(b && rr);
      if (wf) begin
        e.pc   = pc;
        e.inst = pc ^ 32'h5a5a_1234;
        e.exc  = exc;
        exp_q.push_back(e);
      end
      mcount = mcount + int'(wf) - int'(rf);
    end
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_wready", 64'(wr_ready), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_pc", 64'(rd_pc), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // fill, overflow, drain; three rounds to wrap pointers
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++)
        cyc(1, 32'hbfc0_0000 + 32'(4 * i), 0, 0, 0);
      drain(5);
    end

    // concurrent read/write at count 2
    cyc(1, 32'hbfc0_0100, 0, 0, 0);
    cyc(1, 32'hbfc0_0104, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(1, 32'hbfc0_0108 + 32'(4 * i), 0, 1, 0);
    drain(3);

    // flush with count 3 and both handshakes requested
    for (int i = 0; i < 3; i++)
      cyc(1, 32'hbfc0_0200 + 32'(4 * i), 0, 0, 0);
    cyc(1, 32'hbfc0_0300, 0, 1, 1);
    cyc(1, 32'hbfc0_0380, 0, 0, 0);
    drain(2);
    cyc(0, 0, 0, 1, 1);

    // exception field carried verbatim
    cyc(1, 32'hbfc0_0002, 32'h8000_0000, 0, 0);
    drain(2);
    cyc(1, 32'hbfc0_0006, 32'h8000_0004, 1, 0);
    drain(2);

    // asynchronous reset mid-cycle with count 3
    for (int i = 0; i < 3; i++)
      cyc(1, 32'hbfc0_0400 + 32'(4 * i), 0, 0, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    mcount = 0;
    chk("arst_valid", 64'(rd_valid), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_wready", 64'(wr_ready), 64'd1);
    chk("arst_pc", 64'(rd_pc), 64'd0);
    chk("arst_inst", 64'(rd_inst), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, $urandom, $urandom,
          ($urandom % 3) != 0, ($urandom % 25) == 0);
    drain(DEPTH + 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
